serial_adder_n: RTL and testbench

SERIAL_ADDER_N -- requirements
Module: serial_adder_n

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_n_digit_adder.sv | 31 +++
 rtl/serial_adder_n.sv | 124 ++++++++++++
 tb/tb_serial_adder_n.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_adder_pkg;

    // Control states of the serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width for n digits; never narrower than one bit
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_n_digit_adder.sv
// DIGIT-bit ripple-carry adder used once per serial step.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co,
    output logic             cm
);

    // Ripple the carry through the digit; cm is the carry into the top bit
    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        sum  = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]  = x[i] ^ y[i] ^ c[i];
            c[i+1]  = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
        co = c[DIGIT];
        cm = c[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial WIDTH-bit adder (subtract option under SERIAL_ADDER_SUB_EN).
// Latency: out_valid rises WIDTH/DIGIT+1 cycles after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_w(N);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    // Set after the last digit; spends one more cycle in RUN before DONE
    logic             fin;

    logic             sub_i;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_co;
    logic             dig_cm;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    // Operands are shifted down each step, so the current digit is always the low one
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x   (a_q[DIGIT-1:0]),
        .y   (b_q[DIGIT-1:0]),
        .ci  (c_q),
        .sum (dig_sum),
        .co  (dig_co),
        .cm  (dig_cm)
    );

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= 1'b0;
            fin       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        // Subtraction folds into the operands: ~b and inverted carry
                        a_q      <= a;
                        b_q      <= b ^ {WIDTH{sub_i}};
                        c_q      <= carry_in ^ sub_i;
                        cnt      <= '0;
                        fin      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (fin) begin
                        fin       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        s[int'(cnt)*DIGIT +: DIGIT] <= dig_sum;
                        c_q <= dig_co;
                        a_q <= a_q >> DIGIT;
                        b_q <= b_q >> DIGIT;
                        if (cnt == CW'(N - 1)) begin
                            carry_out <= dig_co;
                            overflow  <= dig_cm ^ dig_co;
                            cnt       <= '0;
                            fin       <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n at WIDTH=8, DIGIT=2.
// Latency: expects out_valid five edges after the accepting edge.
// Backpressure: exercises out_ready held low in DONE.
module tb_serial_adder_n;

    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             carry_out;
    logic             overflow;

    int n_checks = 0;
    int n_errs   = 0;

    serial_adder_n #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; called #1 after a clock edge with the DUT in IDLE
    task automatic run_txn(input string tag,
                           input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic tc, input logic tsub, input logic chg,
                           input int hold,
                           input logic [7:0] es, input logic eco, input logic eov);
        int cycles;
        check({tag, "_in_ready"}, in_ready, 1);
        a        = ta;
        b        = tb_v;
        carry_in = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub      = tsub;
`else
        if (tsub) $display("note: %s needs the subtract build", tag);
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (chg) a = 8'hAA;
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, cycles, N + 1);
        check({tag, "_s"}, s, es);
        check({tag, "_carry_out"}, carry_out, eco);
        check({tag, "_overflow"}, overflow, eov);
        check({tag, "_busy"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_s"}, s, es);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_in_ready"}, in_ready, 1);
        check({tag, "_idle_s"}, s, es);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        out_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_carry_out", carry_out, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;

        run_txn("add1", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b0);
        run_txn("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        run_txn("ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b1);
        run_txn("chg",  8'h05, 8'h05, 1'b1, 1'b0, 1'b1, 0, 8'h0B, 1'b0, 1'b0);
        run_txn("hold", 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, 3, 8'h4B, 1'b0, 1'b0);
        run_txn("neg",  8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b1);

        // Reset sampled on the edge that would write digit 2
        a        = 8'h11;
        b        = 8'h22;
        carry_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_s", s, 0);
        check("midrst_carry_out", carry_out, 0);

        run_txn("post", 8'hC0, 8'hC0, 1'b0, 1'b0, 1'b0, 0, 8'h80, 1'b1, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_txn("sub1", 8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 0, 8'hFE, 1'b0, 1'b0);
        run_txn("sub2", 8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 0, 8'h7F, 1'b1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
